alu_issue_queue: RTL and testbench

- Operand/opcode issue stage directly upstream of the 16-bit add/sub/le ALU.
- Accepts {A, B, opcode} requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU's A/B/opcode inputs from the FIFO head, with a registered out_valid/out_ready handshake toward the result-capture stage.
- Filters opcodes the ALU does not implement, so only legal operations reach the datapath.

---
 rtl/alu_issue_queue_if.sv | 35 +++
 rtl/alu_issue_queue.sv | 130 +++++++++++++
 tb/tb_alu_issue_queue.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_queue_if.sv
// Request/issue bundle for alu_issue_queue.
//   master : upstream requester + result-capture side (drives requests and out_ready)
//   slave  : the issue queue (drives in_ready, ALU operands, out_valid, status)
// Signals: in_valid/in_ready/in_a/in_b/in_opcode request handshake,
//          alu_a/alu_b/alu_opcode head operands toward the ALU,
//          out_valid/out_ready issue handshake, illegal_pulse, count occupancy.
interface alu_issue_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_opcode;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_opcode;
  logic             out_valid;
  logic             out_ready;
  logic             illegal_pulse;
  logic [CntW-1:0]  count;

  modport master (
    output in_valid, in_a, in_b, in_opcode, out_ready,
    input  in_ready, alu_a, alu_b, alu_opcode, out_valid, illegal_pulse, count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_opcode, out_ready,
    output in_ready, alu_a, alu_b, alu_opcode, out_valid, illegal_pulse, count
  );
endinterface

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: small FIFO issue stage in front of the 16-bit add/sub/le ALU.
// Accepts {a, b, opcode} requests, silently drops opcodes the ALU does not implement
// (flagging them with a one-cycle illegal_pulse), and presents the head entry to the ALU.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset (flushes pointers and count)
//   bus (slave)   request handshake, ALU head operands, issue handshake, status
// Optional build macro ALU_ISSUE_STATS_EN adds:
//   issued_cnt  (32b, wraps)     number of pops
//   dropped_cnt (16b, saturates) number of illegal opcodes dropped
//   full_cycles (32b, wraps)     cycles spent with the queue full
module alu_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_queue_if.slave    bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]         issued_cnt,
  output logic [15:0]         dropped_cnt,
  output logic [31:0]         full_cycles
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_a  [DEPTH];
  logic [WIDTH-1:0] mem_b  [DEPTH];
  logic [3:0]       mem_op [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            illegal_q, illegal_d;

  logic op_legal;
  logic accept;
  logic push;
  logic pop;
  logic not_empty;

  always_comb begin
    op_legal  = (bus.in_opcode == 4'h0) || (bus.in_opcode == 4'h1) ||
                (bus.in_opcode == 4'h3);
    not_empty = (count_q != '0);
    pop       = not_empty && bus.out_ready;
    // A pop in the same cycle frees a slot, so a full queue keeps accepting while draining.
    bus.in_ready = (count_q != Full) || pop;
    accept    = bus.in_valid && bus.in_ready;
    push      = accept && op_legal;
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    illegal_d = accept && !op_legal;
    count_d   = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Storage is deliberately not reset; only valid entries are ever presented.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_a[wr_ptr_q]  <= bus.in_a;
      mem_b[wr_ptr_q]  <= bus.in_b;
      mem_op[wr_ptr_q] <= bus.in_opcode;
    end
  end

  // Empty queue parks the ALU at ADD 0+0.
  always_comb begin
    bus.out_valid     = not_empty;
    bus.count         = count_q;
    bus.illegal_pulse = illegal_q;
    bus.alu_a         = not_empty ? mem_a[rd_ptr_q]  : '0;
    bus.alu_b         = not_empty ? mem_b[rd_ptr_q]  : '0;
    bus.alu_opcode    = not_empty ? mem_op[rd_ptr_q] : 4'h0;
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issued_q;
  logic [15:0] dropped_q;
  logic [31:0] full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q  <= '0;
      dropped_q <= '0;
      full_q    <= '0;
    end else begin
      if (pop) begin
        issued_q <= issued_q + 32'd1;
      end
      if (accept && !op_legal && (dropped_q != 16'hFFFF)) begin
        dropped_q <= dropped_q + 16'd1;
      end
      if (count_q == Full) begin
        full_q <= full_q + 32'd1;
      end
    end
  end

  assign issued_cnt  = issued_q;
  assign dropped_cnt = dropped_q;
  assign full_cycles = full_q;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: a driver issues directed and random requests and
// queues the expected entries; a negedge monitor compares the DUT against that queue.
module tb_alu_issue_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issued_cnt;
  logic [15:0] dropped_cnt;
  logic [31:0] full_cycles;
  longint exp_issued;
  longint exp_dropped;
  longint exp_full;
`endif

  alu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .issued_cnt  (issued_cnt),
    .dropped_cnt (dropped_cnt),
    .full_cycles (full_cycles)
`endif
  );

  entry_t sb[$];
  logic   exp_illegal = 1'b0;
  logic   started = 1'b0;
  int     checks = 0;
  int     failures = 0;

  function automatic logic is_legal(input logic [3:0] op);
    return (op == 4'h0) || (op == 4'h1) || (op == 4'h3);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; leaves the bench at the next posedge+1.
  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [3:0] op, input logic ordy);
    logic acc;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_opcode = op;
    bus.out_ready = ordy;
    #1;
    acc = v && bus.in_ready;
    @(posedge clk);
    if (acc && is_legal(op)) sb.push_back('{a: a, b: b, op: op});
    exp_illegal = acc && !is_legal(op);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    sb.delete();
    exp_illegal = 1'b0;
`ifdef ALU_ISSUE_STATS_EN
    exp_issued  = 0;
    exp_dropped = 0;
    exp_full    = 0;
`endif
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && started) begin
      automatic int     n   = sb.size();
      automatic logic   pop = (n != 0) && bus.out_ready;
      chk("count", longint'(bus.count), n);
      chk("out_valid", bus.out_valid, n != 0);
      chk("in_ready", bus.in_ready, (n != DEPTH) || pop);
      chk("illegal_pulse", bus.illegal_pulse, exp_illegal);
`ifdef ALU_ISSUE_STATS_EN
      chk("issued_cnt", issued_cnt, exp_issued);
      chk("dropped_cnt", dropped_cnt, exp_dropped);
      chk("full_cycles", full_cycles, exp_full);
      if (n == DEPTH) exp_full++;
      if (pop) exp_issued++;
      if (bus.in_valid && bus.in_ready && !is_legal(bus.in_opcode) && exp_dropped != 65535)
        exp_dropped++;
`endif
      if (n == 0) begin
        chk("alu_a_idle", bus.alu_a, 0);
        chk("alu_b_idle", bus.alu_b, 0);
        chk("alu_opcode_idle", bus.alu_opcode, 0);
      end else begin
        chk("alu_a", bus.alu_a, sb[0].a);
        chk("alu_b", bus.alu_b, sb[0].b);
        chk("alu_opcode", bus.alu_opcode, sb[0].op);
        if (pop) void'(sb.pop_front());
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_opcode = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    started = 1'b1;

    // Single ADD 3+4 with the consumer ready.
    drive(1'b1, 16'h0003, 16'h0004, 4'h0, 1'b1);
    drive(1'b0, '0, '0, 4'h0, 1'b1);
    drive(1'b0, '0, '0, 4'h0, 1'b1);

    // Fill to DEPTH with the consumer stalled, then drain while still pushing.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 16'(16'h100 + i), 16'(i), 4'h1, 1'b0);
    drive(1'b1, 16'hDEAD, 16'hBEEF, 4'h3, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'(16'h200 + i), 16'(i), 4'h0, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, '0, '0, 4'h0, 1'b1);

    // Illegal opcode sandwiched between two SUBs.
    drive(1'b1, 16'h0011, 16'h0001, 4'h1, 1'b0);
    drive(1'b1, 16'h0022, 16'h0002, 4'h2, 1'b0);
    drive(1'b1, 16'h0033, 16'h0003, 4'h1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 4'h0, 1'b1);

    // Back-to-back stream; pointers wrap several times.
    for (int i = 0; i < 20; i++) drive(1'b1, 16'(16'h1000 + i), 16'(16'h2000 + i), 4'h3, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 4'h0, 1'b1);

    // Randomized traffic mixing legal and illegal opcodes and consumer stalls.
    for (int i = 0; i < 400; i++) begin
      automatic logic [3:0] op;
      case ($urandom_range(0, 3))
        0: op = 4'h0;
        1: op = 4'h1;
        2: op = 4'h3;
        default: op = 4'($urandom_range(0, 15));
      endcase
      drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), op,
            $urandom_range(0, 9) < 5);
    end
    for (int i = 0; i < 6; i++) drive(1'b0, '0, '0, 4'h0, 1'b1);

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) drive(1'b1, 16'(16'h55 + i), 16'(16'h66 + i), 4'h0, 1'b0);
    do_reset();
    drive(1'b0, '0, '0, 4'h0, 1'b0);
    drive(1'b1, 16'h0007, 16'h0009, 4'h1, 1'b1);
    drive(1'b0, '0, '0, 4'h0, 1'b1);
    drive(1'b0, '0, '0, 4'h0, 1'b1);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
